// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + busy scoreboard for the register file write port; WBARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: accepted request appears on rf_we/rf_waddr/rf_wdata one cycle later; busy set/clear one edge later.
// Backpressure: only arbitration loss; the losing requester holds its request until its ready is seen.
module regfile_wb_arbiter #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_addr,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_addr,
  input  logic [DW-1:0]        b_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 rsv_ready,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata
);

  logic                 a_win;
  logic [(1<<AW)-1:0]   busy_nxt;

`ifdef WBARB_ROUND_ROBIN_EN
  // Set when A should win the next tie; flips only on ties.
  logic rr_a_turn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_a_turn <= 1'b0;
    end else if (a_valid && b_valid) begin
      rr_a_turn <= ~rr_a_turn;
    end
  end

  assign a_win = a_valid & (~b_valid | rr_a_turn);
`else
  assign a_win = a_valid & ~b_valid;
`endif

  assign a_ready   = a_win;
  assign b_ready   = b_valid & ~a_win;
  assign rsv_ready = ~busy[rsv_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= a_win | b_ready;
      if (a_win) begin
        rf_waddr <= a_addr;
        rf_wdata <= a_data;
      end else if (b_ready) begin
        rf_waddr <= b_addr;
        rf_wdata <= b_data;
      end
    end
  end

  // A new reservation overrides a clear of the same register in the same cycle.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (rsv_valid && rsv_ready) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a transaction-level reference model.
module tb_regfile_wb_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;
`ifdef WBARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic a_valid, b_valid, rsv_valid;
  logic a_ready, b_ready, rsv_ready;
  logic [AW-1:0] a_addr, b_addr, rsv_addr, rf_waddr;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic [15:0] busy;
  logic rf_we;

  regfile_wb_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Register file fed by the DUT write port.
  logic [DW-1:0] tb_rf [16];
  always @(posedge clk) if (rf_we) tb_rf[rf_waddr] <= rf_wdata;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pending write, scoreboard as bit array, expected register contents.
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [15:0]   m_busy;
  logic [DW-1:0] m_mem [16];
  bit            m_a_turn;

  logic obs_ar, obs_br, obs_rr, exp_ar, exp_br, exp_rr;

  task automatic model_reset();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_a_turn = 1'b0;
  endtask

  // Drive one cycle, capture ready outputs, advance the model across the edge.
  task automatic tick(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic rv, input logic [AW-1:0] ra);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    rsv_valid = rv; rsv_addr = ra;
    #1;
    obs_ar = a_ready; obs_br = b_ready; obs_rr = rsv_ready;
    exp_ar = av && (!bv || (RR && m_a_turn));
    exp_br = bv && !exp_ar;
    exp_rr = !m_busy[ra];
    if (m_we) begin
      m_mem[m_waddr] = m_wdata;
      m_busy[m_waddr] = 1'b0;
    end
    if (rv && exp_rr) m_busy[ra] = 1'b1;
    if (exp_ar) begin
      m_we = 1'b1; m_waddr = aa; m_wdata = ad;
    end else if (exp_br) begin
      m_we = 1'b1; m_waddr = ba; m_wdata = bd;
    end else begin
      m_we = 1'b0;
    end
    if (RR && av && bv) m_a_turn = !m_a_turn;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    n_total++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b want 0", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 4'd0) $display("FAIL reset_waddr got %h want 0", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 16'h0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else n_pass++;
    n_total++; if (busy !== 16'h0) $display("FAIL reset_busy got %h want 0", busy); else n_pass++;
  endtask

  task automatic test_single_write();
    tick(1'b1, 4'd3, 16'h1234, 1'b0, '0, '0, 1'b0, '0);
    n_total++; if (obs_ar !== 1'b1) $display("FAIL single_a_ready got %b want 1", obs_ar); else n_pass++;
    n_total++; if (rf_we !== 1'b1) $display("FAIL single_we got %b want 1", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 4'd3) $display("FAIL single_waddr got %h want 3", rf_waddr); else n_pass++;
    n_total++; if (rf_wdata !== 16'h1234) $display("FAIL single_wdata got %h want 1234", rf_wdata); else n_pass++;
    idle();
    n_total++; if (rf_we !== 1'b0) $display("FAIL single_we_after got %b want 0", rf_we); else n_pass++;
    n_total++; if (rf_waddr !== 4'd3) $display("FAIL single_waddr_hold got %h want 3", rf_waddr); else n_pass++;
  endtask

  task automatic test_tie();
    logic want_a;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 4'd1, 16'h0A00 + 16'(i), 1'b1, 4'd2, 16'h0B00 + 16'(i), 1'b0, '0);
      want_a = RR && (i % 2 == 1);
      n_total++; if (obs_ar !== want_a) $display("FAIL tie_a_ready[%0d] got %b want %b", i, obs_ar, want_a); else n_pass++;
      n_total++; if (obs_br !== !want_a) $display("FAIL tie_b_ready[%0d] got %b want %b", i, obs_br, !want_a); else n_pass++;
      n_total++; if (rf_waddr !== (want_a ? 4'd1 : 4'd2)) $display("FAIL tie_waddr[%0d] got %h want %h", i, rf_waddr, want_a ? 4'd1 : 4'd2); else n_pass++;
    end
    idle();
  endtask

  task automatic test_scoreboard();
    tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd5);
    n_total++; if (busy[5] !== 1'b1) $display("FAIL sb_set got %b want 1", busy[5]); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd5);
    n_total++; if (obs_rr !== 1'b0) $display("FAIL sb_rsv_blocked got %b want 0", obs_rr); else n_pass++;
    tick(1'b0, '0, '0, 1'b1, 4'd5, 16'h5555, 1'b0, '0);
    n_total++; if (busy[5] !== 1'b1) $display("FAIL sb_busy_during_we got %b want 1", busy[5]); else n_pass++;
    idle();
    n_total++; if (busy[5] !== 1'b0) $display("FAIL sb_clear got %b want 0", busy[5]); else n_pass++;
    tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd5);
    n_total++; if (obs_rr !== 1'b1) $display("FAIL sb_rsv_again got %b want 1", obs_rr); else n_pass++;
    tick(1'b0, '0, '0, 1'b1, 4'd5, 16'h5A5A, 1'b0, '0);
    idle();
  endtask

  task automatic test_collision();
    tick(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
    tick(1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 16'hBBBB, 1'b0, '0);
    n_total++; if (obs_br !== 1'b1) $display("FAIL coll_b_first got %b want 1", obs_br); else n_pass++;
    tick(1'b1, 4'd7, 16'hAAAA, 1'b0, '0, '0, 1'b0, '0);
    n_total++; if (obs_ar !== 1'b1) $display("FAIL coll_a_second got %b want 1", obs_ar); else n_pass++;
    n_total++; if (busy[7] !== 1'b0) $display("FAIL coll_busy got %b want 0", busy[7]); else n_pass++;
    idle();
    idle();
    n_total++; if (tb_rf[7] !== 16'hAAAA) $display("FAIL coll_final got %h want aaaa", tb_rf[7]); else n_pass++;
  endtask

  task automatic test_random();
    logic ap, bp, rv;
    logic [AW-1:0] aa, ba, ra;
    logic [DW-1:0] ad, bd;
    ap = 1'b0; bp = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && ($urandom_range(0, 1) == 1)) begin ap = 1'b1; aa = AW'($urandom); ad = DW'($urandom); end
      if (!bp && ($urandom_range(0, 2) != 0)) begin bp = 1'b1; ba = AW'($urandom); bd = DW'($urandom); end
      rv = ($urandom_range(0, 2) == 0);
      ra = AW'($urandom);
      tick(ap, aa, ad, bp, ba, bd, rv, ra);
      if (exp_ar) ap = 1'b0;
      if (exp_br) bp = 1'b0;
      n_total++; if (obs_ar !== exp_ar || obs_br !== exp_br) $display("FAIL rnd_grant[%0d] got a%b b%b want a%b b%b", i, obs_ar, obs_br, exp_ar, exp_br); else n_pass++;
      n_total++; if (obs_rr !== exp_rr) $display("FAIL rnd_rsv_ready[%0d] got %b want %b", i, obs_rr, exp_rr); else n_pass++;
      n_total++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) $display("FAIL rnd_wport[%0d] got %b/%h/%h want %b/%h/%h", i, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); else n_pass++;
      n_total++; if (busy !== m_busy) $display("FAIL rnd_busy[%0d] got %h want %h", i, busy, m_busy); else n_pass++;
    end
    idle();
    idle();
    for (int r = 0; r < 16; r++) begin
      n_total++; if (tb_rf[r] !== m_mem[r]) $display("FAIL rnd_rf[%0d] got %h want %h", r, tb_rf[r], m_mem[r]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_write();
    tick(1'b1, 4'd2, 16'hDEAD, 1'b0, '0, '0, 1'b1, 4'd9);
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    n_total++; if (rf_we !== 1'b0) $display("FAIL rst_mid_we got %b want 0", rf_we); else n_pass++;
    n_total++; if (busy !== 16'h0) $display("FAIL rst_mid_busy got %h want 0", busy); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    n_total++; if (rf_we !== 1'b0) $display("FAIL rst_mid_no_write got %b want 0", rf_we); else n_pass++;
    n_total++; if (tb_rf[2] !== m_mem[2]) $display("FAIL rst_mid_dropped got %h want %h", tb_rf[2], m_mem[2]); else n_pass++;
  endtask

  initial begin
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; rsv_valid = 1'b0;
    a_addr = '0; b_addr = '0; rsv_addr = '0; a_data = '0; b_data = '0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_single_write();
    test_tie();
    test_scoreboard();
    test_collision();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
